// File: rtl/capture_fifo.sv
// capture_fifo: trigger-qualified byte capture into an 8 x 8 first-word-fall-through FIFO.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   arm        level: 1 requests capture, 0 ends capture / returns to idle
//   trig_en    1 = start on trig_byte match, 0 = start on first byte after arming
//   trig_byte  trigger pattern compared against in_data
//   in_data    decoded byte from the I2C decoder stage
//   in_valid   decoder valid, may stay high for several cycles per byte
//   rd_en      consumer pop request
//   rd_data    registered FIFO head byte, holds its last value while empty
//   rd_valid   FIFO non-empty
//   count      bytes stored, 0..8
//   state      IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   overflow   sticky overwrite flag (ring mode only, otherwise tied low)
//
// Build option
//   CAPTURE_RING_EN  ring-buffer capture: a full FIFO overwrites its oldest byte
//                    and capture ends only when arm drops.
module capture_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       trig_en,
    input  logic [7:0] trig_byte,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [3:0] count,
    output logic [1:0] state,
    output logic       overflow
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;
`ifdef CAPTURE_RING_EN
    localparam logic RING = 1'b1;
`else
    localparam logic RING = 1'b0;
`endif
    logic [7:0] mem [8];
    logic [2:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [3:0] count_n;
    logic [1:0] state_n;
    logic       in_valid_prev, ev, hit, full, pop, push, ovw, clr;
    logic [7:0] head_n;

    assign ev       = in_valid & ~in_valid_prev;
    assign hit      = ~trig_en | (in_data == trig_byte);
    assign full     = count[3];
    assign rd_valid = count != 4'd0;
    assign pop      = rd_en & rd_valid;
    assign clr      = (state == IDLE) & arm;
    assign push     = (state == ARMED)   ? arm & ev & hit :
                      (state == CAPTURE) ? ev & (~full | pop | RING) : 1'b0;
    // Ring overwrite: a push into a full FIFO with no pop drops the oldest byte.
    assign ovw      = push & full & ~pop;
    assign rd_ptr_n = rd_ptr + {2'b00, pop | ovw};
    assign count_n  = count + {3'b000, push} - {3'b000, pop | ovw};
    // The byte being written lands on the new head when the FIFO was empty
    // (or drained by a same-cycle pop), so bypass the array in that case.
    assign head_n   = (push && wr_ptr == rd_ptr_n) ? in_data : mem[rd_ptr_n];

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = arm ? ARMED : IDLE;
            ARMED:   state_n = !arm ? IDLE : push ? CAPTURE : ARMED;
            CAPTURE: state_n = (!arm || (!RING && count_n[3])) ? DONE : CAPTURE;
            default: state_n = (count == 4'd0 && !arm) ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= 3'd0;
            rd_ptr        <= 3'd0;
            count         <= 4'd0;
            in_valid_prev <= 1'b0;
            rd_data       <= 8'h00;
        end else begin
            in_valid_prev <= in_valid;
            state         <= state_n;
            if (clr) begin
                wr_ptr <= 3'd0;
                rd_ptr <= 3'd0;
                count  <= 4'd0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 3'd1;
                rd_ptr <= rd_ptr_n;
                count  <= count_n;
                if (count_n != 4'd0) rd_data <= head_n;
            end
        end
    end

`ifdef CAPTURE_RING_EN
    logic ovf;
    always_ff @(posedge clk) begin
        if (!rst_n || clr) ovf <= 1'b0;
        else if (ovw) ovf <= 1'b1;
    end
    assign overflow = ovf;
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_capture_fifo.sv
// tb_capture_fifo: directed and random checks of capture_fifo against a queue-based model.
module tb_capture_fifo;
`ifdef CAPTURE_RING_EN
    localparam bit RING = 1'b1;
`else
    localparam bit RING = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n, arm, trig_en, in_valid, rd_en;
    logic [7:0] trig_byte, in_data;
    logic [7:0] rd_data;
    logic       rd_valid, overflow;
    logic [3:0] count;
    logic [1:0] state;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    int         m_state = 0;
    bit         m_ovf = 0;
    bit         m_prev = 0;
    logic [7:0] m_rd = 8'h00;

    capture_fifo dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_byte(trig_byte),
        .in_data(in_data), .in_valid(in_valid), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .state(state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock: update the model from the current inputs, then compare.
    task automatic tick();
        bit ev;
        int n0;
        if (!rst_n) begin
            q.delete(); m_state = 0; m_ovf = 0; m_prev = 0; m_rd = 8'h00;
        end else begin
            ev = in_valid && !m_prev;
            m_prev = in_valid;
            n0 = q.size();
            case (m_state)
                0: if (arm) begin q.delete(); m_ovf = 0; m_state = 1; end
                1: if (!arm) m_state = 0;
                   else if (ev && (!trig_en || in_data == trig_byte)) begin
                       q.push_back(in_data); m_state = 2;
                   end
                2: begin
                    if (rd_en && n0 > 0) void'(q.pop_front());
                    if (ev) begin
                        if (q.size() == 8) begin void'(q.pop_front()); m_ovf = 1; end
                        q.push_back(in_data);
                    end
                    if (!arm || (!RING && q.size() == 8)) m_state = 3;
                end
                default: begin
                    if (rd_en && n0 > 0) void'(q.pop_front());
                    if (n0 == 0 && !arm) m_state = 0;
                end
            endcase
            if (q.size() > 0) m_rd = q[0];
        end
        @(posedge clk);
        #1;
        chk("state", 8'(state), 8'(m_state));
        chk("count", 8'(count), 8'(q.size()));
        chk("rd_valid", 8'(rd_valid), 8'(q.size() > 0));
        chk("rd_data", rd_data, m_rd);
        chk("overflow", 8'(overflow), 8'(m_ovf));
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b; in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_byte = 8'h00;
        in_data = 8'h00; in_valid = 1'b0; rd_en = 1'b0;
        tick(); tick();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", 8'(rd_valid), 8'd0);
        // Free-running trigger: two bytes, pop one.
        rst_n = 1'b1; arm = 1'b1; tick();
        chk("arm_state", 8'(state), 8'd1);
        send(8'hA1);
        chk("cap_state", 8'(state), 8'd2);
        send(8'hB2);
        chk("two_count", 8'(count), 8'd2);
        chk("head_a1", rd_data, 8'hA1);
        pop_one();
        chk("head_b2", rd_data, 8'hB2);
        arm = 1'b0; tick();
        chk("done_state", 8'(state), 8'd3);
        pop_one(); tick();
        chk("idle_state", 8'(state), 8'd0);
        // Pattern trigger: 10 dropped, 50 starts capture.
        arm = 1'b1; trig_en = 1'b1; trig_byte = 8'h50; tick();
        send(8'h10);
        chk("no_trig_count", 8'(count), 8'd0);
        send(8'h50); send(8'h33);
        chk("trig_count", 8'(count), 8'd2);
        chk("trig_head", rd_data, 8'h50);
        // Held valid gives one event.
        in_data = 8'h77; in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0; tick();
        chk("held_count", 8'(count), 8'd3);
        arm = 1'b0; tick();
        repeat (3) pop_one();
        tick();
        chk("drain_idle", 8'(state), 8'd0);
        // Fill past capacity.
        arm = 1'b1; trig_en = 1'b0; tick();
        for (int i = 0; i < 10; i++) send(8'(i));
        chk("fill_count", 8'(count), 8'd8);
        chk("fill_state", 8'(state), RING ? 8'd2 : 8'd3);
        chk("fill_ovf", 8'(overflow), 8'(RING));
        arm = 1'b0; tick();
        for (int i = 0; i < 8; i++) begin
            chk("fill_pop", rd_data, 8'(i + (RING ? 2 : 0)));
            pop_one();
        end
        tick();
        chk("fill_idle", 8'(state), 8'd0);
        // Push and pop together at the fullest CAPTURE level.
        arm = 1'b1; tick();
        for (int i = 0; i < (RING ? 8 : 7); i++) send(8'(8'h40 + i));
        in_data = 8'hEE; in_valid = 1'b1; rd_en = 1'b1; tick();
        in_valid = 1'b0; rd_en = 1'b0; tick();
        chk("pushpop_count", 8'(count), RING ? 8'd8 : 8'd7);
        chk("pushpop_ovf", 8'(overflow), 8'd0);
        chk("pushpop_state", 8'(state), 8'd2);
        rst_n = 1'b0; tick();
        chk("midrst_count", 8'(count), 8'd0);
        chk("midrst_state", 8'(state), 8'd0);
        rst_n = 1'b1; tick();
        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            arm       = ($urandom_range(0, 15) != 0);
            trig_en   = $urandom_range(0, 1) == 1;
            trig_byte = 8'($urandom_range(0, 3));
            in_data   = 8'($urandom_range(0, 7));
            in_valid  = $urandom_range(0, 2) == 0;
            rd_en     = $urandom_range(0, 3) == 0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
